// File: rtl/instr_sequencer.sv
// Four-phase (Q1..Q4) instruction sequencer for the 12-bit-instruction core:
// fetch, decode, execute and write strobes, Z flag and skip-if-zero NOP cycle.
//
// state | meaning
// Q1    | fetch: capture instr when run=1, otherwise hold here
// Q2    | decode: alu_op/f_addr presented from IR, ALU registers result
// Q3    | execute: pc_inc, sample alu_result zero-ness
// Q4    | write: reg_we/w_we, Z update, skip evaluation
module instr_sequencer #(
   parameter logic [3:0] SKIP_OP_A = 4'd11,
   parameter logic [3:0] SKIP_OP_B = 4'd15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic [11:0] instr,
   input  logic [7:0]  alu_result,
   output logic [1:0]  phase,
   output logic        ir_load,
   output logic [3:0]  alu_op,
   output logic [6:0]  f_addr,
   output logic        pc_inc,
   output logic        reg_we,
   output logic        w_we,
   output logic        z_flag,
   output logic        nop_cycle
);

   typedef enum logic [1:0] {
      Q1 = 2'd0,
      Q2 = 2'd1,
      Q3 = 2'd2,
      Q4 = 2'd3
   } phase_t;

   phase_t      state, state_nxt;
   logic [11:0] ir;
   logic        skip_pending;
   logic        running;
   logic        res_zero;
   logic        dest_reg;
   logic        z_op;
   logic        skip_op;

   assign phase  = state;
   assign alu_op = ir[11:8];
   assign f_addr = ir[6:0];

   // MOVWF and CLRF always target the register file; others follow d.
   assign dest_reg = (alu_op <= 4'd1) || ir[7];
   assign z_op     = (alu_op >= 4'd1) && (alu_op <= 4'd10);
   assign skip_op  = (alu_op == SKIP_OP_A) || (alu_op == SKIP_OP_B);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= Q1;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      reg_we    = 1'b0;
      w_we      = 1'b0;
      case (state)
         Q1: begin
            // reset gating keeps ir_load low while reset is held with run=1
            if (run) begin
               state_nxt = Q2;
               ir_load   = reset;
            end
         end
         Q2: state_nxt = Q3;
         Q3: begin
            state_nxt = Q4;
            pc_inc    = running;
         end
         Q4: begin
            state_nxt = Q1;
            if (running && !nop_cycle) begin
               reg_we = dest_reg;
               w_we   = !dest_reg;
            end
         end
         default: state_nxt = Q1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ir           <= 12'd0;
         skip_pending <= 1'b0;
         z_flag       <= 1'b0;
         running      <= 1'b0;
         res_zero     <= 1'b0;
         nop_cycle    <= 1'b0;
      end else begin
         if (ir_load) begin
            ir        <= instr;
            running   <= 1'b1;
            nop_cycle <= skip_pending;
         end
         if (state == Q3)
            res_zero <= (alu_result == 8'd0);
         if (state == Q4) begin
            // a discarded skip instruction never arms another skip
            skip_pending <= skip_op && res_zero && !nop_cycle;
            if (z_op && !nop_cycle)
               z_flag <= res_zero;
         end
      end
   end

endmodule
